// File: rtl/seg_display_mux_if.sv
// Bus between the BCD result register and the seven-segment scanner:
// value/strobe inputs plus the registered segment, decimal point, anode and frame outputs.
interface seg_display_mux_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   dp;
  logic                load;
  logic                blank_en;
  logic [6:0]          seg;
  logic                dp_out;
  logic [DIGITS-1:0]   anode;
  logic                frame_done;

  modport master (
    output bcd, dp, load, blank_en,
    input  seg, dp_out, anode, frame_done
  );

  modport slave (
    input  bcd, dp, load, blank_en,
    output seg, dp_out, anode, frame_done
  );
endinterface

// File: rtl/seg_display_mux.sv
// Multiplexed seven-segment driver: scans a shadowed BCD word one digit per refresh slot,
// with frame-synchronous updates, leading-zero blanking, decimal points and optional hex glyphs.
module seg_display_mux #(
  parameter int unsigned DIGITS           = 4,
  parameter int unsigned REFRESH_DIV      = 50000,
  parameter bit          HEX_MODE         = 1'b0,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_display_mux_if.slave  bus
);
  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam int unsigned BW = 4 * DIGITS;
  localparam logic [DIGITS-1:0] ANODE_OFF = ANODE_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PW-1:0]     prescaler;
  logic [IW-1:0]     index;
  logic [BW-1:0]     stage_bcd;
  logic [DIGITS-1:0] stage_dp;
  logic              pending;
  logic [BW-1:0]     shadow_bcd;
  logic [DIGITS-1:0] shadow_dp;
  logic              boundary_q;
  logic [6:0]        seg_q;
  logic              dp_out_q;
  logic [DIGITS-1:0] anode_q;
  logic              frame_done_q;

  logic              wrap_c;
  logic              boundary_c;
  logic [3:0]        digit_code_c;
  logic              digit_dp_c;
  logic              digit_blank_c;
  logic              seen_c;
  logic [6:0]        seg_next_c;
  logic [DIGITS-1:0] onehot_c;

  function automatic logic [6:0] encode(input logic [3:0] code);
    logic [6:0] glyph;
    glyph = 7'b0111111;
    case (code)
      4'd0:  glyph = 7'b1000000;
      4'd1:  glyph = 7'b1111001;
      4'd2:  glyph = 7'b0100100;
      4'd3:  glyph = 7'b0110000;
      4'd4:  glyph = 7'b0011001;
      4'd5:  glyph = 7'b0010010;
      4'd6:  glyph = 7'b0000010;
      4'd7:  glyph = 7'b1111000;
      4'd8:  glyph = 7'b0000000;
      4'd9:  glyph = 7'b0010000;
      4'd10: glyph = HEX_MODE ? 7'b0001000 : 7'b0111111;
      4'd11: glyph = HEX_MODE ? 7'b0000011 : 7'b0111111;
      4'd12: glyph = HEX_MODE ? 7'b1000110 : 7'b0111111;
      4'd13: glyph = HEX_MODE ? 7'b0100001 : 7'b0111111;
      4'd14: glyph = HEX_MODE ? 7'b0000110 : 7'b0111111;
      4'd15: glyph = HEX_MODE ? 7'b0001110 : 7'b0111111;
      default: glyph = 7'b0111111;
    endcase
    return glyph;
  endfunction

  assign wrap_c     = (prescaler == PW'(REFRESH_DIV - 1));
  assign boundary_c = wrap_c && (index == IW'(DIGITS - 1));

  // Select the scanned digit and decide blanking from the most significant digit downward.
  always_comb begin
    digit_code_c  = 4'd0;
    digit_dp_c    = 1'b0;
    digit_blank_c = 1'b0;
    seen_c        = 1'b0;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      seen_c = seen_c | (shadow_bcd[4*k +: 4] != 4'd0) | shadow_dp[k];
      if (index == IW'(k)) begin
        digit_code_c  = shadow_bcd[4*k +: 4];
        digit_dp_c    = shadow_dp[k];
        digit_blank_c = bus.blank_en && (k != 0) && !seen_c;
      end
    end
  end

  assign seg_next_c = digit_blank_c ? 7'h7F : encode(digit_code_c);
  assign onehot_c   = DIGITS'(1) << index;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler    <= '0;
      index        <= '0;
      stage_bcd    <= '0;
      stage_dp     <= '0;
      pending      <= 1'b0;
      shadow_bcd   <= '0;
      shadow_dp    <= '0;
      boundary_q   <= 1'b0;
      seg_q        <= 7'h7F;
      dp_out_q     <= 1'b1;
      anode_q      <= ANODE_OFF;
      frame_done_q <= 1'b0;
    end else begin
      if (wrap_c) begin
        prescaler <= '0;
        index     <= (index == IW'(DIGITS - 1)) ? '0 : index + IW'(1);
      end else begin
        prescaler <= prescaler + PW'(1);
      end

      if (bus.load) begin
        stage_bcd <= bus.bcd;
        stage_dp  <= bus.dp;
      end

      // A load landing on the boundary itself bypasses staging so it shows next frame.
      if (boundary_c) begin
        pending <= 1'b0;
        if (bus.load) begin
          shadow_bcd <= bus.bcd;
          shadow_dp  <= bus.dp;
        end else if (pending) begin
          shadow_bcd <= stage_bcd;
          shadow_dp  <= stage_dp;
        end
      end else if (bus.load) begin
        pending <= 1'b1;
      end

      boundary_q   <= boundary_c;
      frame_done_q <= boundary_q;
      seg_q        <= seg_next_c;
      dp_out_q     <= digit_blank_c ? 1'b1 : ~digit_dp_c;
      anode_q      <= ANODE_ACTIVE_LOW ? ~onehot_c : onehot_c;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp_out     = dp_out_q;
  assign bus.anode      = anode_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux: per-frame expected images are queued and popped each cycle;
// a second instance with hex glyphs shares the same stimulus.
module tb_seg_display_mux;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned RDIV   = 4;
  localparam int unsigned FRAME  = DIGITS * RDIV;

  localparam logic [6:0] S0   = 7'b1000000;
  localparam logic [6:0] S1   = 7'b1111001;
  localparam logic [6:0] S2   = 7'b0100100;
  localparam logic [6:0] S3   = 7'b0110000;
  localparam logic [6:0] S4   = 7'b0011001;
  localparam logic [6:0] S5   = 7'b0010010;
  localparam logic [6:0] S7   = 7'b1111000;
  localparam logic [6:0] SDSH = 7'b0111111;
  localparam logic [6:0] SHB  = 7'b0000011;
  localparam logic [6:0] SOFF = 7'b1111111;

  typedef struct packed {
    logic [6:0] seg;
    logic [6:0] seg_hex;
    logic       dp_out;
    logic [3:0] anode;
    logic       fd;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  int   cyc;
  exp_t sb[$];

  seg_display_mux_if #(.DIGITS(DIGITS)) bus ();
  seg_display_mux_if #(.DIGITS(DIGITS)) bus_hex ();

  assign bus_hex.bcd      = bus.bcd;
  assign bus_hex.dp       = bus.dp;
  assign bus_hex.load     = bus.load;
  assign bus_hex.blank_en = bus.blank_en;

  seg_display_mux #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV), .HEX_MODE(1'b0), .ANODE_ACTIVE_LOW(1'b1))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  seg_display_mux #(.DIGITS(DIGITS), .REFRESH_DIV(RDIV), .HEX_MODE(1'b1), .ANODE_ACTIVE_LOW(1'b1))
    dut_hex (.clk(clk), .rst_n(rst_n), .bus(bus_hex.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, obs, exp);
      end
  endtask

  // Queue one full frame; segs/dpo are packed with digit 0 in the low bits.
  task automatic push_frame(input logic [27:0] segs, input logic [27:0] segs_hex,
                            input logic [3:0] dpo, input logic fd);
    exp_t e;
    for (int k = 0; k < int'(FRAME); k++) begin
      int d;
      d         = k / int'(RDIV);
      e.seg     = segs[d*7 +: 7];
      e.seg_hex = segs_hex[d*7 +: 7];
      e.dp_out  = dpo[d];
      e.anode   = ~(4'b0001 << d);
      e.fd      = (k == 0) ? fd : 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic step(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 16'(sb.size()), 16'd1);
      end else begin
        e = sb.pop_front();
        chk("seg",        16'(bus.seg),        16'(e.seg));
        chk("seg_hex",    16'(bus_hex.seg),    16'(e.seg_hex));
        chk("dp_out",     16'(bus.dp_out),     16'(e.dp_out));
        chk("anode",      16'(bus.anode),      16'(e.anode));
        chk("frame_done", 16'(bus.frame_done), 16'(e.fd));
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_seg"},     16'(bus.seg),        16'(SOFF));
    chk({tag, "_seg_hex"}, 16'(bus_hex.seg),    16'(SOFF));
    chk({tag, "_dp_out"},  16'(bus.dp_out),     16'd1);
    chk({tag, "_anode"},   16'(bus.anode),      16'hF);
    chk({tag, "_fd"},      16'(bus.frame_done), 16'd0);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] d);
    bus.bcd  = v;
    bus.dp   = d;
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    rst_n       = 1'b0;
    bus.bcd      = '0;
    bus.dp       = '0;
    bus.load     = 1'b0;
    bus.blank_en = 1'b0;

    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;

    // Plain scan of zeros; first frame after reset has no frame_done.
    push_frame({S0, S0, S0, S0}, {S0, S0, S0, S0}, 4'b1111, 1'b0);
    step(16);

    // Mid-frame load only takes effect at the next boundary.
    push_frame({S0, S0, S0, S0}, {S0, S0, S0, S0}, 4'b1111, 1'b1);
    step(5);
    pulse_load(16'h1234, 4'b0000);
    step(10);

    // Two loads in one frame: last one wins.
    push_frame({S1, S2, S3, S4}, {S1, S2, S3, S4}, 4'b1111, 1'b1);
    step(2);
    pulse_load(16'h1111, 4'b0000);
    step(5);
    pulse_load(16'h2222, 4'b0000);
    step(7);

    // Load exactly on the boundary cycle.
    push_frame({S2, S2, S2, S2}, {S2, S2, S2, S2}, 4'b1111, 1'b1);
    step(15);
    pulse_load(16'h5555, 4'b0000);

    push_frame({S5, S5, S5, S5}, {S5, S5, S5, S5}, 4'b1111, 1'b1);
    step(2);
    bus.blank_en = 1'b1;
    pulse_load(16'h0070, 4'b0000);
    step(13);

    // Leading-zero blanking.
    push_frame({SOFF, SOFF, S7, S0}, {SOFF, SOFF, S7, S0}, 4'b1111, 1'b1);
    step(2);
    pulse_load(16'h0000, 4'b0000);
    step(13);

    push_frame({SOFF, SOFF, SOFF, S0}, {SOFF, SOFF, SOFF, S0}, 4'b1111, 1'b1);
    step(2);
    pulse_load(16'h0000, 4'b0100);
    step(13);

    // Decimal point on digit 2 unblanks digits 2 and below.
    push_frame({SOFF, S0, S0, S0}, {SOFF, S0, S0, S0}, 4'b1011, 1'b1);
    step(2);
    pulse_load(16'h00B0, 4'b0000);
    step(13);
    bus.blank_en = 1'b0;

    // Invalid code B: dash in decimal mode, 'b' in hex mode.
    push_frame({S0, S0, SDSH, S0}, {S0, S0, SHB, S0}, 4'b1111, 1'b1);
    step(5);
    pulse_load(16'h9999, 4'b0000);
    step(3);
    rst_n = 1'b0;
    #1;
    chk_reset("async_reset");
    sb.delete();
    repeat (2) @(negedge clk);
    chk_reset("reset_hold");
    rst_n = 1'b1;

    // Pending 9999 must have been discarded by the reset.
    push_frame({S0, S0, S0, S0}, {S0, S0, S0, S0}, 4'b1111, 1'b0);
    step(16);
    push_frame({S0, S0, S0, S0}, {S0, S0, S0, S0}, 4'b1111, 1'b1);
    step(16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
